// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and write-back bypass capture.
// Optional load-use stall counter (StallCnt_o) is built when LOADUSE_STALL_CNT_EN is defined.
module id_ex_stage_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ID_Valid_i,
  input  logic [4:0]        ID_RsAddr_i,
  input  logic [4:0]        ID_RtAddr_i,
  input  logic [4:0]        ID_RdAddr_i,
  input  logic [DATA_W-1:0] ID_RsData_i,
  input  logic [DATA_W-1:0] ID_RtData_i,
  input  logic [DATA_W-1:0] ID_Imm_i,
  input  logic              ID_RegWrite_i,
  input  logic              ID_MemRead_i,
  input  logic              ID_MemWrite_i,
  input  logic              ID_MemtoReg_i,
  input  logic              ID_ALUSrc_i,
  input  logic [1:0]        ID_ALUOp_i,
  input  logic              MEM_WB_RegWrite_i,
  input  logic [4:0]        MEM_WB_RdAddr_i,
  input  logic [DATA_W-1:0] MEM_WB_Data_i,
  input  logic              Flush_i,
  output logic              Stall_o,
  output logic              EX_Valid_o,
  output logic              EX_RegWrite_o,
  output logic              EX_MemRead_o,
  output logic              EX_MemWrite_o,
  output logic              EX_MemtoReg_o,
  output logic              EX_ALUSrc_o,
  output logic [1:0]        EX_ALUOp_o,
  output logic [4:0]        EX_RsAddr_o,
  output logic [4:0]        EX_RtAddr_o,
  output logic [4:0]        EX_RdAddr_o,
  output logic [DATA_W-1:0] EX_RsData_o,
  output logic [DATA_W-1:0] EX_RtData_o,
  output logic [DATA_W-1:0] EX_Imm_o
`ifdef LOADUSE_STALL_CNT_EN
  ,
  output logic [15:0]       StallCnt_o
`endif
);

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              alusrc;
    logic [1:0]        aluop;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [4:0]        rd_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
  } ex_fields_t;

  ex_fields_t ex_q, ex_d;
  logic       hazard;

  // A load in EX whose destination is read by the live decode instruction.
  function automatic logic load_use(input ex_fields_t ex, input logic id_valid,
                                    input logic [4:0] rs, input logic [4:0] rt);
    return id_valid & ex.valid & ex.memread & (ex.rd_addr != 5'd0) &
           ((ex.rd_addr == rs) | (ex.rd_addr == rt));
  endfunction

  // Same-cycle register-file write wins over the stale read data.
  function automatic logic [DATA_W-1:0] wb_bypass(input logic [4:0] rd_addr,
                                                  input logic [DATA_W-1:0] rf_data);
    if (MEM_WB_RegWrite_i && (MEM_WB_RdAddr_i != 5'd0) && (MEM_WB_RdAddr_i == rd_addr))
      return MEM_WB_Data_i;
    return rf_data;
  endfunction

  assign hazard  = load_use(ex_q, ID_Valid_i, ID_RsAddr_i, ID_RtAddr_i);
  assign Stall_o = hazard & ~Flush_i;

  always_comb begin
    ex_d = '0;
    if (!Flush_i && !hazard) begin
      ex_d.valid    = ID_Valid_i;
      ex_d.regwrite = ID_RegWrite_i;
      ex_d.memread  = ID_MemRead_i;
      ex_d.memwrite = ID_MemWrite_i;
      ex_d.memtoreg = ID_MemtoReg_i;
      ex_d.alusrc   = ID_ALUSrc_i;
      ex_d.aluop    = ID_ALUOp_i;
      ex_d.rs_addr  = ID_RsAddr_i;
      ex_d.rt_addr  = ID_RtAddr_i;
      ex_d.rd_addr  = ID_RdAddr_i;
      ex_d.rs_data  = wb_bypass(ID_RsAddr_i, ID_RsData_i);
      ex_d.rt_data  = wb_bypass(ID_RtAddr_i, ID_RtData_i);
      ex_d.imm      = ID_Imm_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign EX_Valid_o    = ex_q.valid;
  assign EX_RegWrite_o = ex_q.regwrite;
  assign EX_MemRead_o  = ex_q.memread;
  assign EX_MemWrite_o = ex_q.memwrite;
  assign EX_MemtoReg_o = ex_q.memtoreg;
  assign EX_ALUSrc_o   = ex_q.alusrc;
  assign EX_ALUOp_o    = ex_q.aluop;
  assign EX_RsAddr_o   = ex_q.rs_addr;
  assign EX_RtAddr_o   = ex_q.rt_addr;
  assign EX_RdAddr_o   = ex_q.rd_addr;
  assign EX_RsData_o   = ex_q.rs_data;
  assign EX_RtData_o   = ex_q.rt_data;
  assign EX_Imm_o      = ex_q.imm;

`ifdef LOADUSE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic inc);
    if (inc && (cnt != 16'hFFFF)) return cnt + 16'd1;
    return cnt;
  endfunction

  assign stall_cnt_d = sat_inc(stall_cnt_q, Stall_o);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) stall_cnt_q <= 16'd0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign StallCnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed scenarios then randomized traffic against a reference model.
module tb_id_ex_stage_reg;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              ID_Valid_i;
  logic [4:0]        ID_RsAddr_i, ID_RtAddr_i, ID_RdAddr_i;
  logic [DATA_W-1:0] ID_RsData_i, ID_RtData_i, ID_Imm_i;
  logic              ID_RegWrite_i, ID_MemRead_i, ID_MemWrite_i, ID_MemtoReg_i, ID_ALUSrc_i;
  logic [1:0]        ID_ALUOp_i;
  logic              MEM_WB_RegWrite_i;
  logic [4:0]        MEM_WB_RdAddr_i;
  logic [DATA_W-1:0] MEM_WB_Data_i;
  logic              Flush_i;
  logic              Stall_o;
  logic              EX_Valid_o, EX_RegWrite_o, EX_MemRead_o, EX_MemWrite_o, EX_MemtoReg_o, EX_ALUSrc_o;
  logic [1:0]        EX_ALUOp_o;
  logic [4:0]        EX_RsAddr_o, EX_RtAddr_o, EX_RdAddr_o;
  logic [DATA_W-1:0] EX_RsData_o, EX_RtData_o, EX_Imm_o;
`ifdef LOADUSE_STALL_CNT_EN
  logic [15:0]       StallCnt_o;
`endif

  always #5 clk = ~clk;

  id_ex_stage_reg #(.DATA_W(DATA_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ID_Valid_i(ID_Valid_i), .ID_RsAddr_i(ID_RsAddr_i), .ID_RtAddr_i(ID_RtAddr_i),
    .ID_RdAddr_i(ID_RdAddr_i), .ID_RsData_i(ID_RsData_i), .ID_RtData_i(ID_RtData_i),
    .ID_Imm_i(ID_Imm_i), .ID_RegWrite_i(ID_RegWrite_i), .ID_MemRead_i(ID_MemRead_i),
    .ID_MemWrite_i(ID_MemWrite_i), .ID_MemtoReg_i(ID_MemtoReg_i), .ID_ALUSrc_i(ID_ALUSrc_i),
    .ID_ALUOp_i(ID_ALUOp_i), .MEM_WB_RegWrite_i(MEM_WB_RegWrite_i),
    .MEM_WB_RdAddr_i(MEM_WB_RdAddr_i), .MEM_WB_Data_i(MEM_WB_Data_i), .Flush_i(Flush_i),
    .Stall_o(Stall_o), .EX_Valid_o(EX_Valid_o), .EX_RegWrite_o(EX_RegWrite_o),
    .EX_MemRead_o(EX_MemRead_o), .EX_MemWrite_o(EX_MemWrite_o), .EX_MemtoReg_o(EX_MemtoReg_o),
    .EX_ALUSrc_o(EX_ALUSrc_o), .EX_ALUOp_o(EX_ALUOp_o), .EX_RsAddr_o(EX_RsAddr_o),
    .EX_RtAddr_o(EX_RtAddr_o), .EX_RdAddr_o(EX_RdAddr_o), .EX_RsData_o(EX_RsData_o),
    .EX_RtData_o(EX_RtData_o), .EX_Imm_o(EX_Imm_o)
`ifdef LOADUSE_STALL_CNT_EN
    , .StallCnt_o(StallCnt_o)
`endif
  );

  // Reference view of what the execute stage should hold.
  typedef struct {
    bit        v, rw, mr, mw, m2r, as;
    bit [1:0]  op;
    bit [4:0]  rs, rt, rd;
    bit [31:0] rsd, rtd, imm;
  } ex_model_t;

  ex_model_t   m;
  int unsigned m_cnt;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hazard();
    return ID_Valid_i && m.v && m.mr && (m.rd != 0) &&
           ((m.rd == ID_RsAddr_i) || (m.rd == ID_RtAddr_i));
  endfunction

  function automatic bit [31:0] reg_read(input bit [4:0] a, input bit [31:0] stale);
    if (MEM_WB_RegWrite_i && MEM_WB_RdAddr_i != 0 && MEM_WB_RdAddr_i == a) return MEM_WB_Data_i;
    return stale;
  endfunction

  task automatic model_edge();
    bit hz;
    hz = model_hazard();
    if (hz && !Flush_i && m_cnt != 32'hFFFF) m_cnt++;
    if (Flush_i || hz) begin
      m = '{default: 0};
    end else begin
      m.v = ID_Valid_i;  m.rw = ID_RegWrite_i; m.mr = ID_MemRead_i; m.mw = ID_MemWrite_i;
      m.m2r = ID_MemtoReg_i; m.as = ID_ALUSrc_i; m.op = ID_ALUOp_i;
      m.rs = ID_RsAddr_i; m.rt = ID_RtAddr_i; m.rd = ID_RdAddr_i; m.imm = ID_Imm_i;
      m.rsd = reg_read(ID_RsAddr_i, ID_RsData_i);
      m.rtd = reg_read(ID_RtAddr_i, ID_RtData_i);
    end
  endtask

  task automatic check_ex(input string tag);
    chk({tag, ".valid"}, EX_Valid_o, m.v);
    chk({tag, ".regwrite"}, EX_RegWrite_o, m.rw);
    chk({tag, ".memread"}, EX_MemRead_o, m.mr);
    chk({tag, ".memwrite"}, EX_MemWrite_o, m.mw);
    chk({tag, ".memtoreg"}, EX_MemtoReg_o, m.m2r);
    chk({tag, ".alusrc"}, EX_ALUSrc_o, m.as);
    chk({tag, ".aluop"}, EX_ALUOp_o, m.op);
    chk({tag, ".rs"}, EX_RsAddr_o, m.rs);
    chk({tag, ".rt"}, EX_RtAddr_o, m.rt);
    chk({tag, ".rd"}, EX_RdAddr_o, m.rd);
    chk({tag, ".rsdata"}, EX_RsData_o, m.rsd);
    chk({tag, ".rtdata"}, EX_RtData_o, m.rtd);
    chk({tag, ".imm"}, EX_Imm_o, m.imm);
`ifdef LOADUSE_STALL_CNT_EN
    chk({tag, ".stallcnt"}, StallCnt_o, m_cnt);
`endif
  endtask

  // Check stall away from the edge, take the edge, then check the registered result.
  task automatic cycle(input string tag);
    @(negedge clk);
    chk({tag, ".stall"}, Stall_o, model_hazard() && !Flush_i);
    @(posedge clk);
    model_edge();
    #1;
    check_ex(tag);
  endtask

  task automatic wb_off();
    MEM_WB_RegWrite_i = 0; MEM_WB_RdAddr_i = 0; MEM_WB_Data_i = 0;
  endtask

  task automatic set_alu(input bit [4:0] rd, input bit [4:0] rs, input bit [4:0] rt);
    ID_Valid_i = 1; ID_RdAddr_i = rd; ID_RsAddr_i = rs; ID_RtAddr_i = rt;
    ID_RsData_i = $urandom; ID_RtData_i = $urandom; ID_Imm_i = $urandom;
    ID_RegWrite_i = 1; ID_MemRead_i = 0; ID_MemWrite_i = 0; ID_MemtoReg_i = 0;
    ID_ALUSrc_i = 0; ID_ALUOp_i = 2'b10; Flush_i = 0;
  endtask

  task automatic set_load(input bit [4:0] rd, input bit [4:0] rs);
    set_alu(rd, rs, rd);
    ID_MemRead_i = 1; ID_MemtoReg_i = 1; ID_ALUSrc_i = 1; ID_ALUOp_i = 2'b00;
  endtask

  task automatic randomize_id();
    ID_Valid_i = ($urandom_range(0, 4) != 0);
    ID_RsAddr_i = 5'($urandom_range(0, 7)); ID_RtAddr_i = 5'($urandom_range(0, 7));
    ID_RdAddr_i = 5'($urandom_range(0, 7));
    ID_RsData_i = $urandom; ID_RtData_i = $urandom; ID_Imm_i = $urandom;
    ID_RegWrite_i = 1'($urandom); ID_MemRead_i = ($urandom_range(0, 4) < 2);
    ID_MemWrite_i = 1'($urandom); ID_MemtoReg_i = 1'($urandom); ID_ALUSrc_i = 1'($urandom);
    ID_ALUOp_i = 2'($urandom);
    MEM_WB_RegWrite_i = 1'($urandom); MEM_WB_RdAddr_i = 5'($urandom_range(0, 7));
    MEM_WB_Data_i = $urandom;
    Flush_i = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    m = '{default: 0};
    m_cnt = 0;
    rst_i = 0;
    // Reset held low with random decode traffic.
    for (int i = 0; i < 3; i++) begin
      randomize_id();
      @(negedge clk);
      check_ex("rst");
      chk("rst.stall", Stall_o, 1'b0);
    end
    @(posedge clk);
    #2 rst_i = 1;

    wb_off(); set_alu(5'd3, 5'd1, 5'd2);
    cycle("add3");
    chk("add3.rd_const", EX_RdAddr_o, 5'd3);
    chk("add3.rw_const", EX_RegWrite_o, 1'b1);

    set_load(5'd5, 5'd1);
    cycle("ld5");
    set_alu(5'd6, 5'd5, 5'd7);
    cycle("use5.bubble");
    chk("use5.bubble_valid", EX_Valid_o, 1'b0);
    chk("use5.stall_gone", Stall_o, 1'b0);
    cycle("use5.load");
    chk("use5.rs_const", EX_RsAddr_o, 5'd5);

    set_load(5'd0, 5'd1);
    cycle("ld0");
    set_alu(5'd6, 5'd0, 5'd0);
    cycle("use0");
    chk("use0.valid_const", EX_Valid_o, 1'b1);

    set_alu(5'd8, 5'd4, 5'd4);
    ID_RsData_i = 0; ID_RtData_i = 0;
    MEM_WB_RegWrite_i = 1; MEM_WB_RdAddr_i = 5'd4; MEM_WB_Data_i = 32'hDEADBEEF;
    cycle("bypass4");
    chk("bypass4.rs_const", EX_RsData_o, 32'hDEADBEEF);
    chk("bypass4.rt_const", EX_RtData_o, 32'hDEADBEEF);
    wb_off();

    set_load(5'd9, 5'd1);
    cycle("ld9");
    set_alu(5'd10, 5'd9, 5'd2); Flush_i = 1;
    cycle("flush_hz");
    chk("flush_hz.valid_const", EX_Valid_o, 1'b0);
    set_alu(5'd11, 5'd3, 5'd4);
    cycle("after_flush");

    // Reset dropped in the middle of a pending stall.
    set_load(5'd12, 5'd1);
    cycle("ld12");
    set_alu(5'd13, 5'd12, 5'd0);
    @(negedge clk);
    chk("midrst.stall_before", Stall_o, 1'b1);
    #1 rst_i = 0;
    #1 m = '{default: 0}; m_cnt = 0;
    check_ex("midrst");
    chk("midrst.stall", Stall_o, 1'b0);
    @(posedge clk);
    #2 rst_i = 1;
    cycle("post_rst");
    chk("post_rst.rd_const", EX_RdAddr_o, 5'd13);

`ifdef LOADUSE_STALL_CNT_EN
    for (int i = 0; i < 3; i++) begin
      set_load(5'd14, 5'd1); cycle("cnt_ld");
      set_alu(5'd15, 5'd2, 5'd14); cycle("cnt_use"); cycle("cnt_go");
    end
    chk("cnt.three", StallCnt_o, 16'd3);
    force dut.stall_cnt_q = 16'hFFFE;
    #1 release dut.stall_cnt_q;
    m_cnt = 32'hFFFE;
    for (int i = 0; i < 3; i++) begin
      set_load(5'd14, 5'd1); cycle("sat_ld");
      set_alu(5'd15, 5'd14, 5'd2); cycle("sat_use"); cycle("sat_go");
    end
    chk("cnt.sat", StallCnt_o, 16'hFFFF);
`endif

    for (int i = 0; i < 400; i++) begin
      randomize_id();
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register with integrated load-use hazard detection and write-back bypass capture. Sits between the decode stage and the execute stage. Registers decoded operands, register addresses and control bits, and supplies the Rs/Rt addresses and control that the EX-stage forwarding logic and ALU operand muxes consume. Inserts a one-cycle bubble and holds PC and IF/ID on a load-use dependency. Kills the decoded instruction on a branch flush.

## Interface
- `DATA_W`, 32, operand and immediate width.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `ID_Valid_i`  in  1  decode slot holds a real instruction.
- `ID_RsAddr_i`, `ID_RtAddr_i`, `ID_RdAddr_i`  in  5 each  decoded register addresses.
- `ID_RsData_i`, `ID_RtData_i`  in  DATA_W each  register-file read data.
- `ID_Imm_i`  in  DATA_W  sign-extended immediate.
- `ID_RegWrite_i`, `ID_MemRead_i`, `ID_MemWrite_i`, `ID_MemtoReg_i`, `ID_ALUSrc_i`  in  1 each  control.
- `ID_ALUOp_i`  in  2  ALU operation class.
- `MEM_WB_RegWrite_i`  in  1  write-back enable.
- `MEM_WB_RdAddr_i`  in  5  write-back address.
- `MEM_WB_Data_i`  in  DATA_W  write-back data.
- `Flush_i`  in  1  branch taken; the decode instruction is wrong-path.
- `Stall_o`  out  1  load-use hazard; hold PC and IF/ID.
- `EX_Valid_o`, `EX_RegWrite_o`, `EX_MemRead_o`, `EX_MemWrite_o`, `EX_MemtoReg_o`, `EX_ALUSrc_o`  out  1 each  registered control.
- `EX_ALUOp_o`  out  2  registered ALU operation class.
- `EX_RsAddr_o`, `EX_RtAddr_o`, `EX_RdAddr_o`  out  5 each  registered addresses.
- `EX_RsData_o`, `EX_RtData_o`, `EX_Imm_o`  out  DATA_W each  registered operands.
- `StallCnt_o`  out  16  load-use stall count; present only with `LOADUSE_STALL_CNT_EN`.

## Operation
**Hazard detection.** This logic is combinational from the registered EX fields and the live ID inputs.
- `hazard = ID_Valid_i & EX_Valid_o & EX_MemRead_o & (EX_RdAddr_o != 0) & ((EX_RdAddr_o == ID_RsAddr_i) | (EX_RdAddr_o == ID_RtAddr_i))`.
- `Stall_o = hazard & ~Flush_i`.

**Per-edge load decision.** Exactly one action is taken, highest priority first:
1. **Flush** (`Flush_i=1`): load a bubble.
2. **Stall** (`hazard`): load a bubble. The decode instruction is re-presented next cycle by the held IF/ID.
3. **Normal**: load all ID inputs.

**Bubble definition.**
- `EX_Valid_o`, `RegWrite`, `MemRead`, `MemWrite`, `MemtoReg`, `ALUSrc` are 0.
- `ALUOp` is 2'b00.
- All addresses are 0.
- Data fields are don't-care; the implementation drives them to 0.

**Write-back bypass.** Applies on a normal load only. If `MEM_WB_RegWrite_i & (MEM_WB_RdAddr_i != 0)`:
- If `MEM_WB_RdAddr_i == ID_RsAddr_i`, register `MEM_WB_Data_i` into `EX_RsData_o` instead of `ID_RsData_i`.
- Rt is handled the same way, independently.
- The bypass covers the register-file read/write in the same cycle.

**Register 0.** An address of 0 never triggers a hazard and never triggers a bypass.

## Timing
- **Reset.** While `rst_i` is low, all `EX_*` outputs are 0 and `StallCnt_o` is 0. `Stall_o` is 0 because `EX_Valid_o` is 0. Reset asserted mid-stall discards the pending stall, and the first edge after release performs a normal load.
- **Latency.** ID inputs appear on `EX_*` one cycle after the edge on which they are sampled.
- **Stall timing.** `Stall_o` is valid in the same cycle as the dependent ID instruction. It lasts exactly one cycle per load-use pair, because the next cycle EX holds a bubble (valid 0).
- **Back-to-back loads.** A load followed by a dependent load stalls once. The second load then occupies EX and may stall its own consumer on the following cycle.
- **Flush with hazard.** When `Flush_i` and `hazard` occur together, `Stall_o` is 0 and a bubble is loaded.
- **Invalid ID.** `ID_Valid_i = 0` never stalls, and a normal load propagates `EX_Valid_o = 0` with its control bits as presented.

## Configuration
- **`LOADUSE_STALL_CNT_EN` defined:**
  - `StallCnt_o` exists.
  - It increments by 1 on each rising edge where `Stall_o = 1`.
  - It saturates at 16'hFFFF.
  - It clears on reset only.
- **Undefined:** the port and counter are absent, and all other behaviour is identical.

## Test plan
- Reset low for 3 cycles with random ID inputs -> all `EX_*` = 0, `Stall_o` = 0. Release, present add x3,x1,x2 -> next cycle `EX_RdAddr_o` = 3, `EX_RegWrite_o` = 1.
- Load x5, then add x6,x5,x7 -> `Stall_o` = 1 for one cycle, EX receives a bubble (`EX_Valid_o` = 0), then the add loads with `EX_RsAddr_o` = 5.
- Load x0, then a consumer of x0 -> no stall.
- Same-cycle write-back x4 = 32'hDEADBEEF, ID reads x4 on both Rs and Rt with stale data 0 -> `EX_RsData_o` = `EX_RtData_o` = 32'hDEADBEEF.
- Load-use hazard with `Flush_i` = 1 -> `Stall_o` = 0 and a bubble is loaded. The next instruction then loads normally.
- With `LOADUSE_STALL_CNT_EN`: 3 load-use pairs -> `StallCnt_o` = 3. Force the counter to 16'hFFFE and stall 3 times -> it holds at 16'hFFFF.
